// File: rtl/fidus_clock_cfg_ctrl.sv
// Round-robin owner of one fidus clock generator's period/phase/enable; every granted change
// runs gate -> apply -> settle -> ungate. Optional counters under FIDUS_CLOCK_CFG_CTRL_STATS_EN.
module fidus_clock_cfg_ctrl #(
  parameter int NUM_REQ       = 2,
  parameter int PERIOD_W      = 32,
  parameter int GATE_CYCLES   = 4,
  parameter int SETTLE_CYCLES = 8,
  parameter int RESET_PERIOD  = 10000,
  parameter bit RESET_CLK_EN  = 1'b1
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic [NUM_REQ-1:0]           i_req,
  input  logic [NUM_REQ*PERIOD_W-1:0]  i_req_period,
  input  logic [NUM_REQ*9-1:0]         i_req_phase,
  input  logic [NUM_REQ-1:0]           i_req_en,
  output logic [NUM_REQ-1:0]           o_gnt,
  output logic [NUM_REQ-1:0]           o_done,
  output logic                         o_err,
  output logic                         o_busy,
  output logic                         o_clk_en,
  output logic [PERIOD_W-1:0]          o_cfg_period,
  output logic [8:0]                   o_cfg_phase,
  output logic                         o_cfg_valid
`ifdef FIDUS_CLOCK_CFG_CTRL_STATS_EN
  ,
  output logic [15:0]                  o_cfg_count,
  output logic [15:0]                  o_err_count
`endif
);

  localparam int MAX_CYC = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_GATE, S_APPLY, S_SETTLE, S_DONE, S_REJECT
  } state_t;

  state_t               r_state, w_next;
  logic [CNT_W-1:0]     r_cnt, w_cnt;
  logic [PTR_W-1:0]     r_ptr, w_ptr;
  logic [NUM_REQ-1:0]   r_gnt, w_gnt;
  logic [NUM_REQ-1:0]   r_done, w_done;
  logic                 r_err, w_err;
  logic                 r_busy;
  logic                 r_clk_en, w_clk_en;
  logic [PERIOD_W-1:0]  r_period, w_period;
  logic [8:0]           r_phase, w_phase;
  logic                 r_valid, w_valid;
  logic                 w_latch;

  logic [PERIOD_W-1:0]  r_lat_period;
  logic [8:0]           r_lat_phase;
  logic                 r_lat_en;

  logic                 w_any;
  logic [PTR_W-1:0]     w_win;
  logic [PTR_W-1:0]     w_idx;
  logic [PERIOD_W-1:0]  w_sel_period;
  logic [8:0]           w_sel_phase;
  logic                 w_sel_en;
  logic                 w_req_ok;

  // Round-robin search starting one past the last winner.
  always_comb begin
    w_any = 1'b0;
    w_win = r_ptr;
    w_idx = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_idx = PTR_W'((int'(r_ptr) + i) % NUM_REQ);
      if (!w_any && i_req[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
  end

  always_comb begin
    w_sel_period = '0;
    w_sel_phase  = '0;
    w_sel_en     = 1'b0;
    for (int n = 0; n < NUM_REQ; n++) begin
      if (w_win == PTR_W'(n)) begin
        w_sel_period = i_req_period[n*PERIOD_W +: PERIOD_W];
        w_sel_phase  = i_req_phase[n*9 +: 9];
        w_sel_en     = i_req_en[n];
      end
    end
  end

  assign w_req_ok = (w_sel_period != '0) && (w_sel_phase <= 9'd359);

  always_comb begin
    w_next   = r_state;
    w_cnt    = r_cnt;
    w_ptr    = r_ptr;
    w_gnt    = r_gnt;
    w_done   = '0;
    w_err    = 1'b0;
    w_clk_en = r_clk_en;
    w_period = r_period;
    w_phase  = r_phase;
    w_valid  = 1'b0;
    w_latch  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_gnt        = '0;
          w_gnt[w_win] = 1'b1;
          w_ptr        = w_win;
          w_latch      = 1'b1;
          w_cnt        = CNT_W'(GATE_CYCLES - 1);
          w_next       = w_req_ok ? S_GATE : S_REJECT;
        end
      end
      S_GATE: begin
        w_clk_en = 1'b0;
        if (r_cnt == '0) w_next = S_APPLY;
        else             w_cnt  = r_cnt - CNT_W'(1);
      end
      S_APPLY: begin
        w_period = r_lat_period;
        w_phase  = r_lat_phase;
        w_valid  = 1'b1;
        w_cnt    = CNT_W'(SETTLE_CYCLES - 1);
        w_next   = S_SETTLE;
      end
      S_SETTLE: begin
        if (r_cnt == '0) w_next = S_DONE;
        else             w_cnt  = r_cnt - CNT_W'(1);
      end
      S_DONE: begin
        w_clk_en = r_lat_en;
        w_done   = r_gnt;
        w_gnt    = '0;
        w_next   = S_IDLE;
      end
      S_REJECT: begin
        w_done = r_gnt;
        w_err  = 1'b1;
        w_gnt  = '0;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_ptr    <= PTR_W'(NUM_REQ - 1);
      r_gnt    <= '0;
      r_done   <= '0;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
      r_clk_en <= RESET_CLK_EN;
      r_period <= PERIOD_W'(RESET_PERIOD);
      r_phase  <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_cnt    <= w_cnt;
      r_ptr    <= w_ptr;
      r_gnt    <= w_gnt;
      r_done   <= w_done;
      r_err    <= w_err;
      r_busy   <= (w_next != S_IDLE);
      r_clk_en <= w_clk_en;
      r_period <= w_period;
      r_phase  <= w_phase;
      r_valid  <= w_valid;
    end
  end

  // Request data is captured once at grant; later input changes are ignored.
  always_ff @(posedge i_clock) begin
    if (w_latch) begin
      r_lat_period <= w_sel_period;
      r_lat_phase  <= w_sel_phase;
      r_lat_en     <= w_sel_en;
    end
  end

  assign o_gnt        = r_gnt;
  assign o_done       = r_done;
  assign o_err        = r_err;
  assign o_busy       = r_busy;
  assign o_clk_en     = r_clk_en;
  assign o_cfg_period = r_period;
  assign o_cfg_phase  = r_phase;
  assign o_cfg_valid  = r_valid;

`ifdef FIDUS_CLOCK_CFG_CTRL_STATS_EN
  logic [15:0] r_cfg_count;
  logic [15:0] r_err_count;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_cfg_count <= '0;
      r_err_count <= '0;
    end else begin
      if (r_state == S_APPLY && r_cfg_count != 16'hFFFF) r_cfg_count <= r_cfg_count + 16'd1;
      if (r_state == S_REJECT && r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
    end
  end

  assign o_cfg_count = r_cfg_count;
  assign o_err_count = r_err_count;
`endif

endmodule

// File: tb/tb_fidus_clock_cfg_ctrl.sv
// Scoreboard bench for fidus_clock_cfg_ctrl: expected completions are queued at stimulus time
// and popped when o_done pulses; cycle-level checks cover gating, apply strobe and reset.
module tb_fidus_clock_cfg_ctrl;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic [1:0]  i_req;
  logic [63:0] i_req_period;
  logic [17:0] i_req_phase;
  logic [1:0]  i_req_en;
  logic [1:0]  o_gnt, o_done;
  logic        o_err, o_busy, o_clk_en, o_cfg_valid;
  logic [31:0] o_cfg_period;
  logic [8:0]  o_cfg_phase;
`ifdef FIDUS_CLOCK_CFG_CTRL_STATS_EN
  logic [15:0] o_cfg_count, o_err_count;
`endif

  fidus_clock_cfg_ctrl dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_req(i_req), .i_req_period(i_req_period),
    .i_req_phase(i_req_phase), .i_req_en(i_req_en), .o_gnt(o_gnt), .o_done(o_done),
    .o_err(o_err), .o_busy(o_busy), .o_clk_en(o_clk_en), .o_cfg_period(o_cfg_period),
    .o_cfg_phase(o_cfg_phase), .o_cfg_valid(o_cfg_valid)
`ifdef FIDUS_CLOCK_CFG_CTRL_STATS_EN
    , .o_cfg_count(o_cfg_count), .o_err_count(o_err_count)
`endif
  );

  always #5 i_clock = ~i_clock;

  typedef struct {
    logic [1:0]  done;
    logic        err;
    logic        clk_en;
    logic [31:0] period;
    logic [8:0]  phase;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Reference model of the generator configuration and arbitration pointer.
  logic        m_en;
  logic [31:0] m_period;
  logic [8:0]  m_phase;
  int          m_ptr;

  task automatic tick;
    @(posedge i_clock);
    #1;
  endtask

  task automatic model_reset;
    m_en = 1'b1; m_period = 32'd10000; m_phase = 9'd0; m_ptr = 1;
  endtask

  task automatic set_req(input int n, input logic [31:0] p, input logic [8:0] ph, input logic en);
    i_req_period[n*32 +: 32] = p;
    i_req_phase[n*9 +: 9]    = ph;
    i_req_en[n]              = en;
  endtask

  task automatic push_exp(input int n, input logic [31:0] p, input logic [8:0] ph,
                          input logic en, input int lat);
    exp_t e;
    logic ok;
    ok = (p != 32'd0) && (ph <= 9'd359);
    if (ok) begin
      m_en = en; m_period = p; m_phase = ph;
    end
    m_ptr    = n;
    e.done   = 2'(1 << n);
    e.err    = !ok;
    e.clk_en = m_en;
    e.period = m_period;
    e.phase  = m_phase;
    e.lat    = lat;
    sb.push_back(e);
  endtask

  task automatic wait_done(input int budget, output logic [1:0] d, output logic er, output int cyc);
    d = '0; er = 1'b0; cyc = -1;
    for (int c = 0; c < budget; c++) begin
      tick();
      cyc++;
      if (o_done != 2'b00) begin
        d = o_done; er = o_err;
        return;
      end
    end
  endtask

  task automatic test_reset;
    int bad;
    i_reset = 1'b1; i_req = '0; i_req_period = '0; i_req_phase = '0; i_req_en = '0;
    model_reset();
    tick(); tick();
    n_tests++;
    if (o_clk_en !== 1'b1 || o_cfg_period !== 32'd10000 || o_cfg_phase !== 9'd0 ||
        o_gnt !== 2'b00 || o_busy !== 1'b0 || o_cfg_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: en=%b per=%0d ph=%0d gnt=%b busy=%b vld=%b, want 1/10000/0/00/0/0",
               o_clk_en, o_cfg_period, o_cfg_phase, o_gnt, o_busy, o_cfg_valid);
    end
    i_reset = 1'b0;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (o_clk_en !== 1'b1 || o_cfg_period !== 32'd10000 || o_cfg_phase !== 9'd0 ||
          o_busy !== 1'b0 || o_cfg_valid !== 1'b0 || o_done !== 2'b00 || o_err !== 1'b0)
        bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL idle_quiet: %0d bad idle cycles, want 0", bad);
    end
`ifdef FIDUS_CLOCK_CFG_CTRL_STATS_EN
    n_tests++;
    if (o_cfg_count !== 16'd0 || o_err_count !== 16'd0) begin
      n_fail++;
      $display("FAIL stats_reset: cfg=%0d err=%0d, want 0/0", o_cfg_count, o_err_count);
    end
`endif
  endtask

  task automatic test_single;
    exp_t e;
    int bad_en;
    logic seen;
    bad_en = 0; seen = 1'b0;
    set_req(0, 32'd8000, 9'd90, 1'b1);
    i_req = 2'b01;
    push_exp(0, 32'd8000, 9'd90, 1'b1, 14);
    for (int k = 0; k <= 20; k++) begin
      tick();
      if (k == 0) begin
        n_tests++;
        if (o_gnt !== 2'b01 || o_clk_en !== 1'b1 || o_busy !== 1'b1) begin
          n_fail++;
          $display("FAIL single_grant: gnt=%b en=%b busy=%b, want 01/1/1", o_gnt, o_clk_en, o_busy);
        end
      end
      if (k >= 1 && k <= 13 && o_clk_en !== 1'b0) bad_en++;
      if (k == 4) begin
        n_tests++;
        if (o_cfg_valid !== 1'b0 || o_cfg_period !== 32'd10000) begin
          n_fail++;
          $display("FAIL single_pre_apply: vld=%b per=%0d, want 0/10000", o_cfg_valid, o_cfg_period);
        end
      end
      if (k == 5) begin
        n_tests++;
        if (o_cfg_valid !== 1'b1 || o_cfg_period !== 32'd8000 || o_cfg_phase !== 9'd90) begin
          n_fail++;
          $display("FAIL single_apply: vld=%b per=%0d ph=%0d, want 1/8000/90",
                   o_cfg_valid, o_cfg_period, o_cfg_phase);
        end
      end
      if (k == 6) begin
        n_tests++;
        if (o_cfg_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL single_strobe_len: vld=%b at cycle 6, want 0", o_cfg_valid);
        end
      end
      if (o_done !== 2'b00 && !seen) begin
        seen = 1'b1;
        e = sb.pop_front();
        n_tests++;
        if (o_done !== e.done || o_err !== e.err || o_clk_en !== e.clk_en ||
            o_cfg_period !== e.period || o_cfg_phase !== e.phase || k != e.lat ||
            o_gnt !== 2'b00 || o_busy !== 1'b0) begin
          n_fail++;
          $display("FAIL single_done: done=%b err=%b en=%b per=%0d cyc=%0d gnt=%b, want %b/%b/%b/%0d/%0d/00",
                   o_done, o_err, o_clk_en, o_cfg_period, k, o_gnt,
                   e.done, e.err, e.clk_en, e.period, e.lat);
        end
        i_req = 2'b00;
      end
    end
    n_tests++;
    if (bad_en != 0 || !seen) begin
      n_fail++;
      $display("FAIL single_gating: %0d cycles with clk_en high, done_seen=%b, want 0/1", bad_en, seen);
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int w0, ndone, bad_en, bad_gnt;
    logic expen;
    ndone = 0; bad_en = 0; bad_gnt = 0;
    w0 = (m_ptr + 1) % 2;
    set_req(0, 32'd12000, 9'd45, 1'b1);
    set_req(1, 32'd20000, 9'd180, 1'b1);
    i_req = 2'b11;
    for (int j = 0; j < 4; j++)
      push_exp((w0 + j) % 2, ((w0 + j) % 2 == 0) ? 32'd12000 : 32'd20000,
               ((w0 + j) % 2 == 0) ? 9'd45 : 9'd180, 1'b1, 15*j + 14);
    for (int k = 0; k < 70 && ndone < 4; k++) begin
      tick();
      expen = ((k % 15) >= 1 && (k % 15) <= 13) ? 1'b0 : 1'b1;
      if (o_clk_en !== expen) bad_en++;
      if ((k % 15) == 0 && o_gnt !== 2'(1 << ((w0 + k/15) % 2))) bad_gnt++;
      if (o_done !== 2'b00) begin
        ndone++;
        if (sb.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL b2b_extra_done: done=%b at cycle %0d, want none", o_done, k);
        end else begin
          e = sb.pop_front();
          n_tests++;
          if (o_done !== e.done || o_err !== e.err || o_cfg_period !== e.period ||
              o_cfg_phase !== e.phase || k != e.lat) begin
            n_fail++;
            $display("FAIL b2b_done: done=%b err=%b per=%0d ph=%0d cyc=%0d, want %b/%b/%0d/%0d/%0d",
                     o_done, o_err, o_cfg_period, o_cfg_phase, k,
                     e.done, e.err, e.period, e.phase, e.lat);
          end
        end
        if (ndone == 4) i_req = 2'b00;
      end
    end
    i_req = 2'b00;
    n_tests++;
    if (bad_en != 0 || bad_gnt != 0 || ndone != 4) begin
      n_fail++;
      $display("FAIL b2b_order: bad_en=%0d bad_gnt=%0d dones=%0d, want 0/0/4", bad_en, bad_gnt, ndone);
    end
    tick(); tick();
  endtask

  task automatic test_reject;
    exp_t e;
    logic [1:0] d;
    logic er;
    int cyc;
    for (int r = 0; r < 2; r++) begin
      if (r == 0) set_req(1, 32'd0, 9'd10, 1'b0);
      else        set_req(1, 32'd7000, 9'd400, 1'b0);
      i_req = 2'b10;
      push_exp(1, i_req_period[63:32], i_req_phase[17:9], 1'b0, 1);
      wait_done(20, d, er, cyc);
      i_req = 2'b00;
      e = sb.pop_front();
      n_tests++;
      if (d !== e.done || er !== e.err || cyc != e.lat || o_clk_en !== e.clk_en ||
          o_cfg_period !== e.period || o_cfg_phase !== e.phase || o_cfg_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reject_%0d: done=%b err=%b cyc=%0d en=%b per=%0d ph=%0d vld=%b, want %b/%b/%0d/%b/%0d/%0d/0",
                 r, d, er, cyc, o_clk_en, o_cfg_period, o_cfg_phase, o_cfg_valid,
                 e.done, e.err, e.lat, e.clk_en, e.period, e.phase);
      end
      tick();
      n_tests++;
      if (o_err !== 1'b0 || o_done !== 2'b00 || o_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL reject_pulse_%0d: err=%b done=%b busy=%b, want 0/00/0", r, o_err, o_done, o_busy);
      end
    end
  endtask

  task automatic test_en_low;
    exp_t e;
    logic [1:0] d;
    logic er;
    int cyc, bad;
    set_req(0, 32'd5000, 9'd0, 1'b0);
    i_req = 2'b01;
    push_exp(0, 32'd5000, 9'd0, 1'b0, 14);
    wait_done(40, d, er, cyc);
    i_req = 2'b00;
    e = sb.pop_front();
    n_tests++;
    if (d !== e.done || er !== e.err || cyc != e.lat || o_clk_en !== e.clk_en ||
        o_cfg_period !== e.period) begin
      n_fail++;
      $display("FAIL en_low_done: done=%b err=%b cyc=%0d en=%b per=%0d, want %b/%b/%0d/%b/%0d",
               d, er, cyc, o_clk_en, o_cfg_period, e.done, e.err, e.lat, e.clk_en, e.period);
    end
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (o_clk_en !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL en_low_hold: %0d idle cycles with clk_en high, want 0", bad);
    end
    set_req(1, 32'd6000, 9'd30, 1'b1);
    i_req = 2'b10;
    push_exp(1, 32'd6000, 9'd30, 1'b1, 14);
    wait_done(40, d, er, cyc);
    i_req = 2'b00;
    e = sb.pop_front();
    n_tests++;
    if (d !== e.done || cyc != e.lat || o_clk_en !== 1'b1 || o_cfg_period !== e.period ||
        o_cfg_phase !== e.phase) begin
      n_fail++;
      $display("FAIL en_restore: done=%b cyc=%0d en=%b per=%0d ph=%0d, want %b/%0d/1/%0d/%0d",
               d, cyc, o_clk_en, o_cfg_period, o_cfg_phase, e.done, e.lat, e.period, e.phase);
    end
    tick();
  endtask

  task automatic test_drop_mid;
    exp_t e;
    logic [1:0] d;
    logic er;
    int cyc;
    set_req(0, 32'd11000, 9'd200, 1'b1);
    i_req = 2'b01;
    push_exp(0, 32'd11000, 9'd200, 1'b1, 14);
    tick();
    set_req(0, 32'd3000, 9'd5, 1'b0);
    tick(); tick(); tick();
    i_req = 2'b00;
    wait_done(40, d, er, cyc);
    e = sb.pop_front();
    n_tests++;
    if (d !== e.done || er !== e.err || cyc + 4 != e.lat || o_clk_en !== e.clk_en ||
        o_cfg_period !== e.period || o_cfg_phase !== e.phase) begin
      n_fail++;
      $display("FAIL drop_mid: done=%b err=%b cyc=%0d en=%b per=%0d ph=%0d, want %b/%b/%0d/%b/%0d/%0d",
               d, er, cyc + 4, o_clk_en, o_cfg_period, o_cfg_phase,
               e.done, e.err, e.lat, e.clk_en, e.period, e.phase);
    end
    tick();
  endtask

  task automatic test_same_cfg;
    exp_t e;
    logic [1:0] d;
    logic er;
    int cyc;
    set_req(1, m_period, m_phase, 1'b1);
    i_req = 2'b10;
    push_exp(1, m_period, m_phase, 1'b1, 14);
    wait_done(40, d, er, cyc);
    i_req = 2'b00;
    e = sb.pop_front();
    n_tests++;
    if (d !== e.done || er !== e.err || cyc != e.lat || o_cfg_period !== e.period) begin
      n_fail++;
      $display("FAIL same_cfg: done=%b err=%b cyc=%0d per=%0d, want %b/%b/%0d/%0d",
               d, er, cyc, o_cfg_period, e.done, e.err, e.lat, e.period);
    end
    tick();
  endtask

  task automatic test_mid_reset;
    exp_t e;
    logic [1:0] d;
    logic er;
    int cyc;
    set_req(0, 32'd9000, 9'd120, 1'b1);
    i_req = 2'b01;
    for (int k = 0; k <= 7; k++) tick();
    n_tests++;
    if (o_clk_en !== 1'b0 || o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_seq_state: en=%b busy=%b at cycle 7, want 0/1", o_clk_en, o_busy);
    end
    i_reset = 1'b1;
    #1;
    n_tests++;
    if (o_clk_en !== 1'b1 || o_cfg_period !== 32'd10000 || o_cfg_phase !== 9'd0 ||
        o_gnt !== 2'b00 || o_busy !== 1'b0 || o_done !== 2'b00 || o_cfg_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_async: en=%b per=%0d ph=%0d gnt=%b busy=%b done=%b, want 1/10000/0/00/0/00",
               o_clk_en, o_cfg_period, o_cfg_phase, o_gnt, o_busy, o_done);
    end
    tick(); tick();
    i_reset = 1'b0;
    i_req = 2'b00;
    model_reset();
    wait_done(20, d, er, cyc);
    n_tests++;
    if (d !== 2'b00) begin
      n_fail++;
      $display("FAIL mid_reset_no_done: done=%b after reset, want 00", d);
    end
`ifdef FIDUS_CLOCK_CFG_CTRL_STATS_EN
    n_tests++;
    if (o_cfg_count !== 16'd0 || o_err_count !== 16'd0) begin
      n_fail++;
      $display("FAIL stats_after_reset: cfg=%0d err=%0d, want 0/0", o_cfg_count, o_err_count);
    end
`endif
    set_req(1, 32'd15000, 9'd270, 1'b1);
    i_req = 2'b10;
    push_exp(1, 32'd15000, 9'd270, 1'b1, 14);
    wait_done(40, d, er, cyc);
    i_req = 2'b00;
    e = sb.pop_front();
    n_tests++;
    if (d !== e.done || er !== e.err || cyc != e.lat || o_clk_en !== e.clk_en ||
        o_cfg_period !== e.period || o_cfg_phase !== e.phase) begin
      n_fail++;
      $display("FAIL post_reset_seq: done=%b err=%b cyc=%0d en=%b per=%0d ph=%0d, want %b/%b/%0d/%b/%0d/%0d",
               d, er, cyc, o_clk_en, o_cfg_period, o_cfg_phase,
               e.done, e.err, e.lat, e.clk_en, e.period, e.phase);
    end
`ifdef FIDUS_CLOCK_CFG_CTRL_STATS_EN
    n_tests++;
    if (o_cfg_count !== 16'd1 || o_err_count !== 16'd0) begin
      n_fail++;
      $display("FAIL stats_count: cfg=%0d err=%0d, want 1/0", o_cfg_count, o_err_count);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_reject();
    test_en_low();
    test_drop_mid();
    test_same_cfg();
    test_mid_reset();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want normal completion");
    $fatal(1, "watchdog");
  end

endmodule
